// File: rtl/ascon_pack.sv
// Shared Ascon constants: default round counts, the 4-bit round index type
// and the per-round constant table used by the constant-addition layer.
package ascon_pack;

   // Default round counts for the two permutation flavours.
   localparam int ASCON_ROUNDS_A = 12;
   localparam int ASCON_ROUNDS_B = 6;

   // Round indices run 0..11; a shorter permutation starts later in the table.
   localparam int ROUND_MAX = 12;

   typedef logic [3:0] round_t;

   localparam round_t ROUND_LAST = 4'd11;

   // Constant added in round 'round': high nibble counts down, low nibble up.
   function automatic logic [7:0] round_constant(input round_t round);
      return {4'hf - round, round};
   endfunction

endpackage

// File: rtl/round_counter.sv
// 4-bit loadable up-counter holding the current permutation round index.
module round_counter
   import ascon_pack::*;
(
   input  logic   clock_i,
   input  logic   resetb_i,
   input  logic   load,
   input  round_t load_value,
   input  logic   enable,
   output round_t count
);

   // Round index register: load has priority over increment.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its inputs.
   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (enable) begin
         count <= count + round_t'(1);
      end
   end

endmodule

// File: rtl/round_sequencer.sv
// Ascon permutation round sequencer: runs p^a (NB_ROUNDS_A rounds) or p^b
// (NB_ROUNDS_B rounds) and drives the round index, state enable, input-mux
// select and completion pulse of the permutation datapath.
// Optional feature: define ROUND_HOLD_EN to let hold_i pause a run in place.
module round_sequencer
   import ascon_pack::*;
#(
   parameter int NB_ROUNDS_A = ASCON_ROUNDS_A,
   parameter int NB_ROUNDS_B = ASCON_ROUNDS_B
)
(
   input  logic       clock_i,
   input  logic       resetb_i,
   input  logic       start_i,
   input  logic       mode_i,
   input  logic       hold_i,
   output logic [3:0] round_o,
   output logic       en_round_o,
   output logic       init_o,
   output logic       busy_o,
   output logic       done_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FIRST = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Every run ends on round 11, so a shorter run starts further into the
   // table. For the default p^a count the start index is 0.
   localparam round_t START_A = round_t'(ROUND_MAX - NB_ROUNDS_A);
   localparam round_t START_B = round_t'(ROUND_MAX - NB_ROUNDS_B);

   state_t state;
   state_t state_next;
   round_t round;
   logic   cnt_load;
   round_t cnt_load_value;
   logic   cnt_enable;
   logic   held;

`ifdef ROUND_HOLD_EN
   // Pause request; only consulted while a run is in FIRST or RUN.
   assign held = hold_i;
`else
   // Hold is not built: the port exists for a uniform interface only.
   logic unused_hold;
   assign unused_hold = hold_i;
   assign held        = 1'b0;
`endif

   round_counter u_round_counter (
      .clock_i    (clock_i),
      .resetb_i   (resetb_i),
      .load       (cnt_load),
      .load_value (cnt_load_value),
      .enable     (cnt_enable),
      .count      (round)
   );

   assign round_o = round;

   // State register.
   // NOTE: asynchronous reset drops any run in progress straight to IDLE,
   // so an aborted run never produces a done pulse.
   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state, counter control and state-decoded outputs.
   // NOTE: every signal driven here gets a default first, so no path through
   // the case can leave one unassigned and infer a latch.
   always_comb begin
      state_next     = state;
      cnt_load       = 1'b0;
      cnt_load_value = '0;
      cnt_enable     = 1'b0;
      en_round_o     = 1'b0;
      init_o         = 1'b0;
      busy_o         = 1'b0;
      done_o         = 1'b0;

      case (state)
         IDLE: begin
            if (start_i) begin
               cnt_load       = 1'b1;
               cnt_load_value = mode_i ? START_B : START_A;
               state_next     = FIRST;
            end
         end

         FIRST, RUN: begin
            busy_o     = 1'b1;
            init_o     = (state == FIRST);
            en_round_o = !held;
            if (!held) begin
               if (round == ROUND_LAST) begin
                  // Last round: index stays at 11, never wraps.
                  state_next = DONE;
               end else begin
                  cnt_enable = 1'b1;
                  state_next = RUN;
               end
            end
         end

         DONE: begin
            busy_o         = 1'b1;
            done_o         = 1'b1;
            // Return the index to 0 for the idle period.
            cnt_load       = 1'b1;
            cnt_load_value = '0;
            state_next     = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_round_sequencer.sv
// Scoreboard bench for round_sequencer: each stimulus cycle pushes the
// expected output vector, which is popped and compared mid-cycle.
module tb_round_sequencer;

   localparam int NB_A = 12;
   localparam int NB_B = 6;
`ifdef ROUND_HOLD_EN
   localparam bit HOLD_EN = 1'b1;
`else
   localparam bit HOLD_EN = 1'b0;
`endif

   logic       clock_i  = 1'b0;
   logic       resetb_i = 1'b1;
   logic       start_i  = 1'b0;
   logic       mode_i   = 1'b0;
   logic       hold_i   = 1'b0;
   logic [3:0] round_o;
   logic       en_round_o;
   logic       init_o;
   logic       busy_o;
   logic       done_o;

   typedef struct packed {
      logic [3:0] round;
      logic       en;
      logic       init;
      logic       busy;
      logic       done;
   } obs_t;

   typedef struct {
      obs_t exp;
      bit   s;
      bit   m;
      bit   h;
   } rec_t;

   obs_t sb[$];
   rec_t plan[$];
   int   errors = 0;
   int   checks = 0;

   round_sequencer #(
      .NB_ROUNDS_A (NB_A),
      .NB_ROUNDS_B (NB_B)
   ) dut (
      .clock_i    (clock_i),
      .resetb_i   (resetb_i),
      .start_i    (start_i),
      .mode_i     (mode_i),
      .hold_i     (hold_i),
      .round_o    (round_o),
      .en_round_o (en_round_o),
      .init_o     (init_o),
      .busy_o     (busy_o),
      .done_o     (done_o)
   );

   always #5 clock_i = ~clock_i;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got round=%0d en/init/busy/done=%b, want round=%0d en/init/busy/done=%b",
                  tag, $time, got[7:4], got[3:0], exp[7:4], exp[3:0]);
      end
   endtask

   function automatic obs_t sample();
      return {round_o, en_round_o, init_o, busy_o, done_o};
   endfunction

   function automatic obs_t mk(input int r, input bit en, input bit init, input bit busy, input bit done);
      obs_t o;
      o.round = 4'(r);
      o.en    = en;
      o.init  = init;
      o.busy  = busy;
      o.done  = done;
      return o;
   endfunction

   // Append one run to the plan: the IDLE cycle that presents start, then
   // one entry per cycle. Rounds above stop_round are dropped (aborted run).
   function automatic void build(input bit mode, input int hold_round, input int hold_len,
                                 input int poke_round, input int stop_round, input bit keep_start);
      int r0;
      r0 = mode ? (12 - NB_B) : (12 - NB_A);
      plan.push_back('{exp: obs_t'(0), s: 1'b1, m: mode, h: 1'b0});
      for (int r = r0; r <= 11 && r <= stop_round; r++) begin
         if (HOLD_EN && r == hold_round) begin
            for (int k = 0; k < hold_len; k++)
               plan.push_back('{exp: mk(r, 0, r == r0, 1, 0), s: keep_start, m: !mode, h: 1'b1});
         end
         plan.push_back('{exp: mk(r, 1, r == r0, 1, 0),
                          s: keep_start || (r == poke_round),
                          m: !mode,
                          h: !HOLD_EN && (r >= hold_round) && (r < hold_round + hold_len)});
      end
      if (stop_round >= 11)
         plan.push_back('{exp: mk(11, 0, 0, 1, 1), s: keep_start, m: !mode, h: hold_len > 0});
   endfunction

   task automatic observe(input string tag);
      obs_t e;
      e = (sb.size() > 0) ? sb.pop_front() : obs_t'(0);
      check(tag, sample(), e);
   endtask

   // Drive the plan one cycle at a time: inputs just after the rising edge,
   // outputs compared on the falling edge.
   task automatic play(input string tag);
      rec_t r;
      while (plan.size() > 0) begin
         r = plan.pop_front();
         @(posedge clock_i);
         #1;
         start_i = r.s;
         mode_i  = r.m;
         hold_i  = r.h;
         sb.push_back(r.exp);
         @(negedge clock_i);
         observe(tag);
      end
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(posedge clock_i);
         #1;
         start_i = 1'b0;
         mode_i  = 1'b0;
         hold_i  = 1'b0;
         sb.push_back(obs_t'(0));
         @(negedge clock_i);
         observe(tag);
      end
   endtask

   initial begin
      // Power-on reset.
      #1 resetb_i = 1'b0;
      #2 check("rst_init", sample(), obs_t'(0));
      repeat (2) @(negedge clock_i);
      check("rst_hold", sample(), obs_t'(0));
      resetb_i = 1'b1;
      idle(2, "idle0");

      // p^a: rounds 0..11, done 13 cycles after the start cycle.
      build(1'b0, -1, 0, -1, 99, 1'b0);
      play("pa");
      idle(2, "pa_idle");

      // p^b: rounds 6..11, busy for 7 cycles.
      build(1'b1, -1, 0, -1, 99, 1'b0);
      play("pb");
      idle(2, "pb_idle");

      // start (with mode flipped) pulsed at round 4 of p^a is ignored.
      build(1'b0, -1, 0, 4, 99, 1'b0);
      play("poke");
      idle(3, "poke_idle");

      // hold for 3 cycles at round 5 of p^a (ignored in the default build).
      build(1'b0, 5, 3, -1, 99, 1'b0);
      play("hold_pa");
      idle(2, "hold_idle");

      // hold for 2 cycles in FIRST of p^b.
      build(1'b1, 6, 2, -1, 99, 1'b0);
      play("hold_first");
      idle(2, "holdf_idle");

      // Asynchronous reset at round 7 of p^a aborts without done.
      build(1'b0, -1, 0, -1, 7, 1'b0);
      play("abort");
      #2 resetb_i = 1'b0;
      #1 check("rst_async", sample(), obs_t'(0));
      idle(2, "in_rst");
      @(negedge clock_i);
      resetb_i = 1'b1;
      idle(2, "post_rst");
      build(1'b1, -1, 0, -1, 99, 1'b0);
      play("pb_restart");
      idle(2, "restart_idle");

      // start held high: two p^a runs with one IDLE cycle between (period 14).
      build(1'b0, -1, 0, -1, 99, 1'b1);
      build(1'b0, -1, 0, -1, 99, 1'b1);
      play("b2b");
      idle(3, "b2b_idle");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Absolute time bound so the run always ends on its own.
   initial begin
      #200000;
      $display("FAIL timeout: bench did not reach its summary");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/round_sequencer.md
ROUND_SEQUENCER -- requirements
Module: round_sequencer

Interface
REQ-001 Parameter NB_ROUNDS_A, default 12: rounds of the p^a permutation (initialisation/finalisation); legal range 1..12.
REQ-002 Parameter NB_ROUNDS_B, default 6: rounds of the p^b permutation (data processing); legal range 1..NB_ROUNDS_A.
REQ-003 clock_i  input  1  single clock; all state updates on its rising edge.
REQ-004 resetb_i  input  1  reset, asynchronous, active-low.
REQ-005 start_i  input  1  request one permutation run; sampled only in IDLE.
REQ-006 mode_i  input  1  0 = p^a, 1 = p^b; sampled with start_i.
REQ-007 hold_i  input  1  pause the run in place (active only with ROUND_HOLD_EN).
REQ-008 round_o  output  4  round index driven to the constant-addition round_i input.
REQ-009 en_round_o  output  1  permutation state register enable for the current round.
REQ-010 init_o  output  1  selects external state into the permutation input mux (first round only).
REQ-011 busy_o  output  1  high from the FIRST cycle through the DONE cycle.
REQ-012 done_o  output  1  one-cycle pulse: permutation result valid.

Function
REQ-013 FSM states SHALL be IDLE, FIRST, RUN, DONE.
REQ-014 IDLE: start_i=1 SHALL load round_o with 0 (mode_i=0) or 12-NB_ROUNDS_B (mode_i=1) and go to FIRST; else stay.
REQ-015 FIRST: init_o=1, en_round_o=1 (unless held); next edge round_o+1 and go RUN, or go DONE if round_o was 11.
REQ-016 RUN: init_o=0, en_round_o=1 (unless held); round_o increments by 1 each un-held cycle.
REQ-017 RUN/FIRST with round_o=11 and not held SHALL go to DONE; round_o SHALL never exceed 11 or wrap.
REQ-018 DONE: done_o=1, en_round_o=0, round_o holds 11; next edge go IDLE unconditionally.
REQ-019 Latency, no hold: done_o high exactly NB_ROUNDS_A+1 (p^a) or NB_ROUNDS_B+1 (p^b) cycles after the edge sampling start_i.
REQ-020 start_i outside IDLE (including DONE) SHALL be ignored; mode_i ignored except with start_i in IDLE.
REQ-021 Back-to-back: start_i held high SHALL start a new run on the cycle after DONE (one IDLE cycle between runs).
REQ-022 p^a sequence 0..11; p^b sequence 6..11 with defaults; round_o in IDLE = 0.
REQ-023 Outputs en_round_o, init_o, busy_o, done_o SHALL be decoded from state only (Moore), no combinational path from inputs except hold_i gating of en_round_o.

Reset
REQ-024 resetb_i=0 SHALL force IDLE, round_o=0, all 1-bit outputs 0, immediately and independent of clock.
REQ-025 Reset mid-run SHALL abort the run without a done_o pulse; first start_i after release begins a fresh run.

Configuration
REQ-026 Macro ROUND_HOLD_EN defined: hold_i=1 in FIRST/RUN freezes state and round_o and forces en_round_o=0 (init_o stays 1 in FIRST); hold_i ignored in IDLE/DONE.
REQ-027 Macro ROUND_HOLD_EN undefined: port hold_i present but ignored; no hold logic synthesised.

Structure
REQ-028 NB_ROUNDS_A/NB_ROUNDS_B default constants and the 4-bit round index type SHALL live in ascon_pack next to round_constant; FSM state enum stays local.
REQ-029 One sub-module round_counter (4-bit loadable up-counter: load, load value, enable) SHALL hold round_o; FSM in round_sequencer.

Verification
REQ-030 Reset then start_i=1, mode_i=0 one cycle -> round_o 0..11 on 12 consecutive cycles, init_o only with 0, done_o single pulse 13 cycles after start.
REQ-031 start_i=1, mode_i=1 -> round_o 6..11, done_o 7 cycles after start, busy_o high 7 cycles.
REQ-032 start_i pulsed at round_o=4 of a p^a run -> ignored, run completes unchanged, no second done_o.
REQ-033 resetb_i low at round_o=7 asynchronously -> outputs 0 same cycle, no done_o; restart p^b yields 6..11.
REQ-034 ROUND_HOLD_EN, hold_i=1 for 3 cycles at round_o=5 -> round_o stays 5, en_round_o=0 for 3 cycles, done_o delayed to 16 cycles after start.
REQ-035 start_i held high constantly, mode_i=0 -> DONE, one IDLE cycle, new FIRST with round_o=0, period 14 cycles.
